// File: rtl/hex_uart_dumper.sv
// FIFO-buffered word dumper: renders each word as upper-case ASCII hex on a byte UART.
// Optional HEX_DUMP_OVF_MARK_EN inserts '!' before the first word after an overflow.
module hex_uart_dumper #(
    parameter int          DATA_W         = 8,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          WORDS_PER_LINE = 8,
    parameter logic [7:0]  SEP_CHAR       = 8'h20
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [7:0]                    uart_byte_o,
    output logic                          uart_dv_o,
    input  logic                          uart_done_i,
    input  logic                          clear_ovf_i,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int NDIG = DATA_W / 4;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int DCW  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int WCW  = (WORDS_PER_LINE > 0) ? $clog2(WORDS_PER_LINE + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, LOAD, SEND_DIG, WAIT_DIG, SEND_SEP, WAIT_SEP,
        SEND_CR, WAIT_CR, SEND_LF, WAIT_LF
`ifdef HEX_DUMP_OVF_MARK_EN
        , SEND_MARK, WAIT_MARK
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [DATA_W-1:0]    shreg_q, shreg_d;
    logic [DCW-1:0]       dig_q, dig_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d, wcnt_inc;
    logic [7:0]           byte_q, byte_d;
    logic [7:0]           char;
    logic                 dv, full, empty, push, pop, drop, line_end;
`ifdef HEX_DUMP_OVF_MARK_EN
    logic                 mark_q, mark_d, mark_clr;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign push     = valid_i && !full;
    assign drop     = valid_i && full;
    assign pop      = (state_q == LOAD);
    assign wcnt_inc = wcnt_q + WCW'(1);
    assign line_end = (WORDS_PER_LINE != 0) && (wcnt_inc == WCW'(WORDS_PER_LINE));

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
        // a dropped push beats a same-cycle clear
        ovf_d = drop ? 1'b1 : (clear_ovf_i ? 1'b0 : ovf_q);
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dig_d   = dig_q;
        wcnt_d  = wcnt_q;
        dv      = 1'b0;
        char    = 8'h00;
`ifdef HEX_DUMP_OVF_MARK_EN
        mark_clr = 1'b0;
`endif
        unique case (state_q)
            IDLE: if (!empty) state_d = LOAD;
            LOAD: begin
                shreg_d = mem_q[rd_ptr_q];
                dig_d   = DCW'(NDIG - 1);
`ifdef HEX_DUMP_OVF_MARK_EN
                state_d = mark_q ? SEND_MARK : SEND_DIG;
`else
                state_d = SEND_DIG;
`endif
            end
            SEND_DIG: begin
                dv      = 1'b1;
                char    = hex_ascii(shreg_q[DATA_W-1 -: 4]);
                state_d = WAIT_DIG;
            end
            WAIT_DIG: if (uart_done_i) begin
                shreg_d = shreg_q << 4;
                if (dig_q != '0) begin
                    dig_d   = dig_q - DCW'(1);
                    state_d = SEND_DIG;
                end else if (line_end) begin
                    wcnt_d  = '0;
                    state_d = SEND_CR;
                end else begin
                    wcnt_d  = (WORDS_PER_LINE != 0) ? wcnt_inc : '0;
                    state_d = SEND_SEP;
                end
            end
            SEND_SEP: begin
                dv      = 1'b1;
                char    = SEP_CHAR;
                state_d = WAIT_SEP;
            end
            WAIT_SEP: if (uart_done_i) state_d = IDLE;
            SEND_CR: begin
                dv      = 1'b1;
                char    = 8'h0D;
                state_d = WAIT_CR;
            end
            WAIT_CR: if (uart_done_i) state_d = SEND_LF;
            SEND_LF: begin
                dv      = 1'b1;
                char    = 8'h0A;
                state_d = WAIT_LF;
            end
            WAIT_LF: if (uart_done_i) state_d = IDLE;
`ifdef HEX_DUMP_OVF_MARK_EN
            SEND_MARK: begin
                dv      = 1'b1;
                char    = 8'h21;
                state_d = WAIT_MARK;
            end
            WAIT_MARK: if (uart_done_i) begin
                mark_clr = 1'b1;
                state_d  = SEND_DIG;
            end
`endif
            default: state_d = IDLE;
        endcase
        byte_d = dv ? char : byte_q;
    end

`ifdef HEX_DUMP_OVF_MARK_EN
    assign mark_d = (ovf_d && !ovf_q) || (mark_q && !mark_clr);
`endif

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            shreg_q  <= '0;
            dig_q    <= '0;
            wcnt_q   <= '0;
            byte_q   <= 8'h00;
`ifdef HEX_DUMP_OVF_MARK_EN
            mark_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            shreg_q  <= shreg_d;
            dig_q    <= dig_d;
            wcnt_q   <= wcnt_d;
            byte_q   <= byte_d;
`ifdef HEX_DUMP_OVF_MARK_EN
            mark_q   <= mark_d;
`endif
        end
    end

    assign ready_o      = !full;
    assign uart_dv_o    = dv;
    assign uart_byte_o  = byte_d;
    assign overflow_o   = ovf_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_hex_uart_dumper.sv
// Bench for hex_uart_dumper: queue-based character stream model plus directed
// literal checks for latency, line breaks, overflow and mid-word reset.
module tb_hex_uart_dumper;

    localparam int         DW    = 8;
    localparam int         DEPTH = 4;
    localparam int         WPL   = 2;
    localparam int         NDIG  = DW / 4;
    localparam int         CW    = $clog2(DEPTH) + 1;
    localparam logic [7:0] SEP   = 8'h20;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [7:0]    uart_byte_o;
    logic          uart_dv_o;
    logic          uart_done_i = 1'b0;
    logic          clear_ovf_i = 1'b0;
    logic          overflow_o;
    logic [CW-1:0] fifo_count_o;

    int         errs = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         line_pos = 0;
    logic       ovf_m = 1'b0;
    logic [7:0] last_b = 8'h00;
    logic       prev_dv = 1'b0;
    int         dv_cnt = 0;
    bit         mark_pend = 0;
    bit         hold = 0;
    int         fix_dly = 0;
    bit         resp_pend = 0;
    int         resp_dly = 0;

    hex_uart_dumper #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .WORDS_PER_LINE(WPL), .SEP_CHAR(SEP)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .uart_byte_o(uart_byte_o), .uart_dv_o(uart_dv_o),
        .uart_done_i(uart_done_i), .clear_ovf_i(clear_ovf_i),
        .overflow_o(overflow_o), .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] asc(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    // Character stream a word must produce, given its position in the line.
    function automatic void model_word(input logic [DW-1:0] w);
        for (int i = NDIG - 1; i >= 0; i--)
            exp_q.push_back(asc(int'((w >> (4 * i)) & 'hF)));
        line_pos++;
        if (WPL != 0 && line_pos == WPL) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            line_pos = 0;
        end else begin
            exp_q.push_back(SEP);
        end
    endfunction

    always @(negedge clk) begin
        if (reset_i) begin
            prev_dv = 1'b0;
        end else begin
            if (uart_dv_o) begin
                dv_cnt++;
                got_q.push_back(uart_byte_o);
                chk("dv_single_cycle", prev_dv, 1'b0);
`ifdef HEX_DUMP_OVF_MARK_EN
                if (mark_pend && uart_byte_o == 8'h21) begin
                    mark_pend = 0;
                    checks++;
                end else
`endif
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL unexpected_strobe: got %0h expected none", uart_byte_o);
                end else begin
                    chk("uart_byte", uart_byte_o, exp_q.pop_front());
                end
                last_b = uart_byte_o;
            end else begin
                chk("byte_hold", uart_byte_o, last_b);
            end
            prev_dv = uart_dv_o;
            chk("overflow", overflow_o, ovf_m);
            if (valid_i && ready_o) model_word(data_i);
            if (valid_i && !ready_o) begin
                if (!ovf_m) mark_pend = 1;
                ovf_m = 1'b1;
            end else if (clear_ovf_i) begin
                ovf_m = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            uart_done_i = 1'b0;
            if (uart_dv_o && !reset_i) begin
                resp_pend = 1;
                resp_dly  = (fix_dly > 0) ? fix_dly : int'($urandom_range(1, 4));
            end else if (resp_pend && !hold) begin
                if (resp_dly <= 1) begin
                    uart_done_i = 1'b1;
                    resp_pend   = 0;
                end else begin
                    resp_dly--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        line_pos  = 0;
        ovf_m     = 1'b0;
        last_b    = 8'h00;
        mark_pend = 0;
        resp_pend = 0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        model_reset();
        tick();
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic push(input logic [DW-1:0] w);
        valid_i = 1'b1;
        data_i  = w;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || resp_pend) && n < 3000) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_got(input string name, input logic [7:0] e[$]);
        chk({name, "_len"}, got_q.size(), e.size());
        for (int i = 0; i < e.size() && i < got_q.size(); i++)
            chk(name, got_q[i], e[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] e[$];
        int n;
        int d0;
        int exp_cnt[6] = '{1, 2, 2, 3, 4, 4};
        int exp_rdy[6] = '{1, 1, 1, 1, 0, 0};
        int exp_ovf[6] = '{0, 0, 0, 0, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_dv", uart_dv_o, 1'b0);
        chk("rst_byte", uart_byte_o, 8'h00);
        chk("rst_ovf", overflow_o, 1'b0);
        chk("rst_count", fifo_count_o, 0);
        reset_i = 1'b0;
        tick();

        // single word: latency, digits, strobe count
        fix_dly = 3;
        got_q.delete();
        d0 = dv_cnt;
        push(8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uart_dv_o && n < 10);
        chk("t1_latency", n, 3);
        drain("t1");
        e = '{8'h41, 8'h35, 8'h20};
        check_got("t1_bytes", e);
        chk("t1_dv_count", dv_cnt - d0, 3);

        // reset while waiting on the first digit of 0xC3
        fix_dly = 4;
        got_q.delete();
        push(8'hC3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!uart_dv_o && n < 10);
        chk("t6_first_strobe", n, 3);
        tick();
        reset_i = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_dv", uart_dv_o, 1'b0);
        chk("t6_rst_byte", uart_byte_o, 8'h00);
        chk("t6_rst_ready", ready_o, 1'b1);
        chk("t6_rst_ovf", overflow_o, 1'b0);
        chk("t6_rst_count", fifo_count_o, 0);
        tick();
        reset_i = 1'b0;
        repeat (20) tick();
        chk("t6_quiet", got_q.size(), 0);
        push(8'h07);
        drain("t6");
        e = '{8'h30, 8'h37, 8'h20};
        check_got("t6_bytes", e);

        // line breaks every two words
        do_reset();
        fix_dly = 0;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        drain("t3");
        e = '{8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h0D, 8'h0A, 8'h30, 8'h33, 8'h20};
        check_got("t3_bytes", e);

        // back-pressure, fill, overflow and clear
        do_reset();
        hold = 1;
        fix_dly = 1;
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1;
            data_i  = DW'(8'h10 + i);
            tick();
            chk("t4_count", fifo_count_o, exp_cnt[i]);
            chk("t4_ready", ready_o, exp_rdy[i]);
            chk("t4_ovf", overflow_o, exp_ovf[i]);
        end
        valid_i = 1'b0;
        clear_ovf_i = 1'b1;
        tick();
        clear_ovf_i = 1'b0;
        chk("t4_clear", overflow_o, 1'b0);
        valid_i = 1'b1;
        clear_ovf_i = 1'b1;
        data_i = 8'h99;
        tick();
        valid_i = 1'b0;
        clear_ovf_i = 1'b0;
        chk("t5_set_wins", overflow_o, 1'b1);
        chk("t5_count_full", fifo_count_o, DEPTH);
        clear_ovf_i = 1'b1;
        tick();
        clear_ovf_i = 1'b0;
        hold = 0;
        drain("t4");

        // randomized traffic against the stream model
        do_reset();
        fix_dly = 0;
        repeat (600) begin
            valid_i     = ($urandom_range(0, 2) != 0);
            data_i      = DW'($urandom);
            clear_ovf_i = ($urandom_range(0, 15) == 0);
            hold        = ($urandom_range(0, 9) < 2);
            tick();
        end
        valid_i = 1'b0;
        clear_ovf_i = 1'b0;
        hold = 0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/hex_uart_dumper.md
Name: hex_uart_dumper

Overview:
Debug streaming block that buffers incoming data words in a FIFO and renders each one as upper-case ASCII hex over a byte-wide UART transmitter interface. Each word is followed by a separator; CR/LF is inserted every WORDS_PER_LINE words. Sits between any capture source (PS/2 receiver, sand-engine probes) and UART_TX. It replaces single-byte, unbuffered hex echo logic.

Parameters:
DATA_W, 8, word width in bits; multiple of 4, range 4..32; hex digits per word NDIG = DATA_W/4.
FIFO_DEPTH, 16, FIFO entries; power of 2, at least 2.
WORDS_PER_LINE, 8, words per line before CR/LF; 0 disables line breaks.
SEP_CHAR, 8'h20, separator byte sent after each word that does not end a line.

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous, active-high reset
data_i  in  DATA_W  word to dump
valid_i  in  1  push request for data_i
ready_o  in/out=out  1  high when FIFO not full; a push is accepted iff valid_i && ready_o
uart_byte_o  out  8  byte to the UART (TX_byte)
uart_dv_o  out  1  one-cycle strobe; uart_byte_o valid (TX_DV)
uart_done_i  in  1  one-cycle pulse from the UART when the current byte has finished
clear_ovf_i  in  1  clears overflow_o
overflow_o  out  1  sticky; set when a push is attempted while the FIFO is full
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: ready_o=1, uart_dv_o=0, uart_byte_o=8'h00, overflow_o=0, fifo_count_o=0. FSM goes to IDLE, line word counter=0, FIFO is emptied.
- FIFO: synchronous write and read, registered count. ready_o = !full, based on registered state.
- Push while full: the word is dropped and overflow_o is set on the next edge.
- Simultaneous push and pop: both take effect and the count is unchanged. A push to an empty FIFO is not visible to the FSM until the following cycle (no bypass).
- clear_ovf_i clears overflow_o. If clear_ovf_i and a dropped push occur in the same cycle, set wins.
- FSM states: IDLE, LOAD, SEND_DIG, WAIT_DIG, SEND_SEP, WAIT_SEP, SEND_CR, WAIT_CR, SEND_LF, WAIT_LF. Optional states exist only under the macro below.
- IDLE -> LOAD when the FIFO is not empty.
- LOAD: pop the head word into a shift register and set the digit counter to NDIG-1.
- SEND_DIG: uart_dv_o=1 for exactly one cycle, uart_byte_o = ASCII of the top nibble. Nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46.
- WAIT_DIG: hold until uart_done_i. Then shift the word left by 4 and decrement the counter. Go to SEND_DIG while digits remain; otherwise increment the word counter.
- End of line: if WORDS_PER_LINE != 0 and the word counter reaches WORDS_PER_LINE, reset the counter to 0 and go SEND_CR (0x0D) -> WAIT_CR -> SEND_LF (0x0A) -> WAIT_LF -> IDLE.
- Otherwise: SEND_SEP (SEP_CHAR) -> WAIT_SEP -> IDLE.
- uart_byte_o holds its value until the next strobe. uart_dv_o is never asserted outside SEND_* states.
- uart_done_i outside WAIT_* states is ignored.
- Latency: a word pushed at edge N into an empty FIFO while the FSM is IDLE gives the FSM non-empty at N+1 (LOAD, pop), the first uart_dv_o in the cycle after N+2, and the first char strobe at edge N+3.
- Reset mid-word aborts the output immediately; the remaining characters and the line position are lost.
- Clock-gating/back-pressure: the FSM stalls indefinitely in WAIT_* states; the FIFO keeps accepting words until full.

Optional Feature:
HEX_DUMP_OVF_MARK_EN
- Defined: when overflow_o rises, a pending-mark flag is set. Before the next word's first digit, the FSM sends '!' (0x21) via SEND_MARK/WAIT_MARK, then clears the flag. The mark does not count toward WORDS_PER_LINE.
- Undefined: no mark states exist; overflow is reported only on overflow_o.

Test Plan:
1. DATA_W=8: push 0xA5, uart_done_i returned 3 cycles after each strobe -> bytes 0x41,0x35,0x20. First strobe 3 cycles after the push; uart_dv_o is high exactly 3 cycles in total.
2. DATA_W=16: push 0x1F0C -> 0x31,0x46,0x30,0x43,0x20.
3. WORDS_PER_LINE=2: push 0x01,0x02,0x03 back-to-back -> "01 02\r\n03 ", i.e. 0x30,0x31,0x20,0x30,0x32,0x0D,0x0A,0x30,0x33,0x20.
4. FIFO_DEPTH=4, uart_done_i held off: push 6 words -> ready_o low after 5 accepted (4 in FIFO, 1 in shift register), 6th dropped, overflow_o=1. clear_ovf_i -> overflow_o=0. With the macro defined, '!' precedes the next word after release.
5. Push and pop in the same cycle at count=2 -> count stays 2. Push at count=FIFO_DEPTH with clear_ovf_i -> overflow_o=1.
6. Assert reset_i in WAIT_DIG after the first digit of 0xC3 -> outputs at reset values immediately. No further strobes; the next pushed 0x07 prints "07 " at line position 0.
